// File: rtl/pea_pkg.sv
// Shared PEA types and defaults used by the shared division arbiter.
package pea_pkg;

    localparam int unsigned N_DIV_REQ  = 4;
    localparam int unsigned N_DIV_BITS = 32;

    typedef enum logic [1:0] {
        DA_IDLE = 2'd0,
        DA_BUSY = 2'd1,
        DA_RESP = 2'd2
    } div_arb_state_t;

endpackage

// File: rtl/div_iter_core.sv
// Iterative restoring unsigned divider: one quotient bit per enabled cycle,
// with an immediate shortcut for a zero divisor.
module div_iter_core
    import pea_pkg::*;
#(
    parameter int unsigned N_BITS = N_DIV_BITS
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              i_start,
    input  logic              i_enable,
    input  logic [N_BITS-1:0] i_a,
    input  logic [N_BITS-1:0] i_b,
    output logic              o_done_c,
    output logic [N_BITS-1:0] o_quo,
    output logic [N_BITS-1:0] o_rem
);

    localparam int unsigned CNT_W = $clog2(N_BITS);

    logic [N_BITS-1:0] r_quo;
    logic [N_BITS-1:0] r_rem;
    logic [N_BITS-1:0] r_b;
    logic [CNT_W-1:0]  r_cnt;

    logic [N_BITS:0]   w_shift;
    logic [N_BITS:0]   w_diff;
    logic              w_bit;
    logic              w_last;
    logic              w_b_zero;

    // Extra top bit keeps the trial subtraction exact for divisors above 2^(N_BITS-1).
    assign w_shift  = {r_rem, r_quo[N_BITS-1]};
    assign w_diff   = w_shift - {1'b0, r_b};
    assign w_bit    = ~w_diff[N_BITS];
    assign w_last   = (r_cnt == CNT_W'(N_BITS - 1));
    assign w_b_zero = (i_b == '0);

    assign o_done_c = (i_start & w_b_zero) | (i_enable & w_last);
    assign o_quo    = r_quo;
    assign o_rem    = r_rem;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_quo <= '0;
            r_rem <= '0;
            r_b   <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_b   <= i_b;
            r_cnt <= '0;
            if (w_b_zero) begin
                r_quo <= '1;
                r_rem <= i_a;
            end else begin
                r_quo <= i_a;
                r_rem <= '0;
            end
        end else if (i_enable) begin
            r_quo <= {r_quo[N_BITS-2:0], w_bit};
            r_rem <= w_bit ? w_diff[N_BITS-1:0] : w_shift[N_BITS-1:0];
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/s_div_arbiter.sv
// Round-robin arbiter sharing one iterative divider among N_REQ PEs,
// frozen entirely by the global pea_ready_i stall.
module s_div_arbiter
    import pea_pkg::*;
#(
    parameter int unsigned N_REQ     = N_DIV_REQ,
    parameter int unsigned N_BITS    = N_DIV_BITS,
    parameter int unsigned LOG_N_REQ = $clog2(N_REQ)
) (
    input  logic                           clk_i,
    input  logic                           rst_n_i,
    input  logic                           pea_ready_i,
    input  logic [N_REQ-1:0]               req_valid_i,
    input  logic [N_REQ-1:0][N_BITS-1:0]   req_a_i,
    input  logic [N_REQ-1:0][N_BITS-1:0]   req_b_i,
    input  logic [N_REQ-1:0]               req_rem_i,
    output logic [N_REQ-1:0]               req_ready_o,
    output logic [N_REQ-1:0]               resp_valid_o,
    input  logic [N_REQ-1:0]               resp_ready_i,
    output logic [N_BITS-1:0]              res_o,
    output logic [N_BITS-1:0]              rem_q_o,
    output logic                           busy_o,
    output logic [LOG_N_REQ-1:0]           grant_idx_o
);

    localparam int unsigned IDX_W = LOG_N_REQ + 1;

    div_arb_state_t       r_state;
    div_arb_state_t       w_state_nxt;
    logic [LOG_N_REQ-1:0] r_rr_ptr;
    logic [LOG_N_REQ-1:0] w_rr_nxt;
    logic [LOG_N_REQ-1:0] r_owner;
    logic                 r_rem_sel;

    logic [IDX_W-1:0]     w_cand;
    logic [LOG_N_REQ-1:0] w_win_idx;
    logic                 w_win_found;
    logic                 w_hs;
    logic                 w_step;
    logic                 w_done;
    logic [N_BITS-1:0]    w_quo;
    logic [N_BITS-1:0]    w_rem;

    // First valid requester at or after r_rr_ptr, with wrap.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_cand      = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            w_cand = IDX_W'(r_rr_ptr) + IDX_W'(k);
            if (w_cand >= IDX_W'(N_REQ)) begin
                w_cand = w_cand - IDX_W'(N_REQ);
            end
            if (!w_win_found && req_valid_i[w_cand[LOG_N_REQ-1:0]]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_cand[LOG_N_REQ-1:0];
            end
        end
    end

    assign w_hs   = (r_state == DA_IDLE) & w_win_found & pea_ready_i & rst_n_i;
    assign w_step = (r_state == DA_BUSY) & pea_ready_i;

    div_iter_core #(
        .N_BITS (N_BITS)
    ) u_core (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .i_start  (w_hs),
        .i_enable (w_step),
        .i_a      (req_a_i[w_win_idx]),
        .i_b      (req_b_i[w_win_idx]),
        .o_done_c (w_done),
        .o_quo    (w_quo),
        .o_rem    (w_rem)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        case (r_state)
            DA_IDLE: begin
                if (w_hs) begin
                    w_state_nxt = w_done ? DA_RESP : DA_BUSY;
                end
            end
            DA_BUSY: begin
                if (w_step && w_done) begin
                    w_state_nxt = DA_RESP;
                end
            end
            DA_RESP: begin
                if (pea_ready_i && resp_ready_i[r_owner]) begin
                    w_state_nxt = DA_IDLE;
                    w_rr_nxt    = (r_owner == LOG_N_REQ'(N_REQ - 1)) ? '0
                                                                     : r_owner + LOG_N_REQ'(1);
                end
            end
            default: w_state_nxt = DA_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state   <= DA_IDLE;
            r_rr_ptr  <= '0;
            r_owner   <= '0;
            r_rem_sel <= 1'b0;
        end else if (pea_ready_i) begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_nxt;
            if (w_hs) begin
                r_owner   <= w_win_idx;
                r_rem_sel <= req_rem_i[w_win_idx];
            end
        end
    end

    // Response side is decoded purely from registered state.
    always_comb begin
        req_ready_o  = '0;
        resp_valid_o = '0;
        res_o        = '0;
        rem_q_o      = '0;
        grant_idx_o  = '0;
        busy_o       = (r_state != DA_IDLE);
        if (w_hs) begin
            req_ready_o[w_win_idx] = 1'b1;
        end
        if (r_state != DA_IDLE) begin
            grant_idx_o = r_owner;
        end
        if (r_state == DA_RESP) begin
            resp_valid_o[r_owner] = 1'b1;
            res_o                 = r_rem_sel ? w_rem : w_quo;
            rem_q_o               = r_rem_sel ? w_quo : w_rem;
        end
    end

endmodule

// File: tb/tb_s_div_arbiter.sv
// Self-checking bench for s_div_arbiter: directed cases plus randomized jobs
// against a plain-arithmetic round-robin/division reference model.
module tb_s_div_arbiter;

    localparam int NR = 4;
    localparam int NB = 32;

    logic                  clk;
    logic                  rst_n;
    logic                  pea_ready;
    logic [NR-1:0]         req_valid;
    logic [NR-1:0][NB-1:0] req_a;
    logic [NR-1:0][NB-1:0] req_b;
    logic [NR-1:0]         req_rem;
    logic [NR-1:0]         req_ready;
    logic [NR-1:0]         resp_valid;
    logic [NR-1:0]         resp_ready;
    logic [NB-1:0]         res;
    logic [NB-1:0]         rem_q;
    logic                  busy;
    logic [1:0]            grant_idx;

    int n_chk;
    int n_err;
    int ptr;

    s_div_arbiter #(.N_REQ(NR), .N_BITS(NB)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .pea_ready_i  (pea_ready),
        .req_valid_i  (req_valid),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .req_rem_i    (req_rem),
        .req_ready_o  (req_ready),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .res_o        (res),
        .rem_q_o      (rem_q),
        .busy_o       (busy),
        .grant_idx_o  (grant_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_pick(input logic [NR-1:0] mask, input int p);
        for (int k = 0; k < NR; k++) begin
            if (mask[(p + k) % NR]) return (p + k) % NR;
        end
        return 0;
    endfunction

    function automatic void ref_div(input logic [NB-1:0] a, input logic [NB-1:0] b,
                                    output logic [NB-1:0] q, output logic [NB-1:0] r);
        if (b == 0) begin
            q = '1;
            r = a;
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    function automatic logic [NB-1:0] rnd_b();
        case ($urandom_range(0, 4))
            0: return '0;
            1: return NB'($urandom_range(1, 15));
            2: return 32'h8000_0000 | NB'($urandom);
            3: return 32'd1;
            default: return NB'($urandom);
        endcase
    endfunction

    function automatic logic [NB-1:0] rnd_a();
        case ($urandom_range(0, 3))
            0: return '0;
            1: return NB'($urandom_range(0, 20));
            default: return NB'($urandom);
        endcase
    endfunction

    task automatic set_req(input int i, input logic [NB-1:0] a, input logic [NB-1:0] b, input logic r);
        req_a[i]   = a;
        req_b[i]   = b;
        req_rem[i] = r;
    endtask

    // One complete job for the model-predicted winner, starting in an IDLE cycle.
    task automatic do_job(input int idx, input int stall_at, input int stall_len, input int bp_len);
        logic [NB-1:0] a, b, q, r, exp_res, exp_rq;
        logic          rsel;
        logic [NR-1:0] oh;
        int            lat, exp_lat;
        bit            got;
        oh      = '0;
        oh[idx] = 1'b1;
        a       = req_a[idx];
        b       = req_b[idx];
        rsel    = req_rem[idx];
        ref_div(a, b, q, r);
        exp_res = rsel ? r : q;
        exp_rq  = rsel ? q : r;
        exp_lat = (b == 0) ? 1 : NB + 1 + stall_len;
        resp_ready[idx] = (bp_len == 0);
        #1;
        chk("grant", 64'(req_ready), 64'(oh));
        chk("idle_no_resp", 64'(resp_valid), 64'd0);
        cyc();
        // Owner's inputs change while the job runs; they must be ignored.
        req_a[idx]   = NB'($urandom);
        req_b[idx]   = NB'($urandom);
        req_rem[idx] = 1'($urandom);
        lat = 1;
        got = 0;
        while (!got && lat < 200) begin
            if (stall_len > 0 && lat == stall_at) pea_ready = 1'b0;
            if (stall_len > 0 && lat == stall_at + stall_len) pea_ready = 1'b1;
            #1;
            if (!pea_ready) begin
                chk("stall_busy", 64'(busy), 64'd1);
                chk("stall_owner", 64'(grant_idx), 64'(idx));
                chk("stall_rv", 64'(resp_valid), 64'd0);
                chk("stall_rdy", 64'(req_ready), 64'd0);
            end
            if (resp_valid == oh) got = 1;
            else begin
                cyc();
                lat++;
            end
        end
        pea_ready = 1'b1;
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("res", 64'(res), 64'(exp_res));
        chk("rem_q", 64'(rem_q), 64'(exp_rq));
        chk("resp_owner", 64'(grant_idx), 64'(idx));
        chk("resp_busy", 64'(busy), 64'd1);
        chk("resp_no_rdy", 64'(req_ready), 64'd0);
        for (int c = 0; c < bp_len; c++) begin
            cyc();
            chk("bp_rv", 64'(resp_valid), 64'(oh));
            chk("bp_res", {res, rem_q}, {exp_res, exp_rq});
            chk("bp_rdy", 64'(req_ready), 64'd0);
        end
        resp_ready[idx] = 1'b1;
        cyc();
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_res", {res, rem_q}, 64'd0);
        chk("idle_grant", 64'(grant_idx), 64'd0);
        chk("idle_rv", 64'(resp_valid), 64'd0);
        ptr = (idx + 1) % NR;
    endtask

    initial begin
        int w, sa, sl, bp, quiet_bad;
        n_chk      = 0;
        n_err      = 0;
        ptr        = 0;
        rst_n      = 1'b0;
        pea_ready  = 1'b1;
        req_valid  = '0;
        req_rem    = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = '1;
        repeat (3) cyc();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rv", 64'(resp_valid), 64'd0);
        chk("rst_outs", {res, rem_q}, 64'd0);
        chk("rst_grant", 64'(grant_idx), 64'd0);
        rst_n = 1'b1;
        cyc();

        set_req(0, 100, 7, 1'b0);
        req_valid = 4'b0001;
        do_job(rr_pick(req_valid, ptr), 0, 0, 0);
        set_req(0, 100, 7, 1'b1);
        do_job(rr_pick(req_valid, ptr), 0, 0, 0);

        set_req(1, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
        req_valid = 4'b0010;
        do_job(rr_pick(req_valid, ptr), 10, 5, 0);

        for (int i = 0; i < NR; i++) set_req(i, rnd_a(), 32'd3 + NB'($urandom_range(0, 99)), 1'($urandom));
        req_valid = 4'b1011;
        do_job(rr_pick(req_valid, ptr), 0, 0, 10);

        set_req(2, 32'h1234, 32'd0, 1'b0);
        req_valid = 4'b0100;
        do_job(rr_pick(req_valid, ptr), 0, 0, 0);

        // Reset in the middle of a job discards it and rewinds the pointer.
        set_req(3, NB'($urandom), 32'd5, 1'b0);
        req_valid = 4'b1000;
        #1;
        chk("pre_rst_grant", 64'(req_ready), 64'b1000);
        cyc();
        repeat (5) cyc();
        chk("pre_rst_busy", 64'(busy), 64'd1);
        req_valid = '0;
        rst_n     = 1'b0;
        cyc();
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_rv", 64'(resp_valid), 64'd0);
        chk("mid_rst_outs", {res, rem_q}, 64'd0);
        chk("mid_rst_grant", 64'(grant_idx), 64'd0);
        rst_n     = 1'b1;
        ptr       = 0;
        quiet_bad = 0;
        for (int c = 0; c < 40; c++) begin
            cyc();
            if (resp_valid != 0 || busy) quiet_bad++;
        end
        chk("no_resp_after_rst", 64'(quiet_bad), 64'd0);
        set_req(1, 32'd77, 32'd8, 1'b0);
        set_req(3, 32'd55, 32'd6, 1'b0);
        req_valid = 4'b1010;
        do_job(rr_pick(req_valid, ptr), 0, 0, 0);

        req_valid = 4'b1111;
        for (int i = 0; i < NR; i++) set_req(i, rnd_a(), rnd_b(), 1'($urandom));
        for (int j = 0; j < 5; j++) do_job(rr_pick(req_valid, ptr), 0, 0, 0);

        for (int it = 0; it < 30; it++) begin
            req_valid = NR'($urandom_range(1, 15));
            for (int i = 0; i < NR; i++) set_req(i, rnd_a(), rnd_b(), 1'($urandom));
            w  = rr_pick(req_valid, ptr);
            sa = 0;
            sl = 0;
            if (req_b[w] != 0 && $urandom_range(0, 2) == 0) begin
                sa = $urandom_range(2, 25);
                sl = $urandom_range(1, 6);
            end
            bp = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
            do_job(w, sa, sl, bp);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/s_div_arbiter.md
Name: s_div_arbiter

Overview:
- Shares one iterative unsigned divider among N_REQ streaming division PEs in the PEA.
- Accepts operand pairs through per-requester valid/ready handshakes and arbitrates round-robin.
- Runs one restoring-division step per enabled cycle and returns quotient/remainder to the granted requester.
- Honours the global pea_ready_i stall, like every other PEA pipeline stage.

Parameters:
- N_REQ, 4, number of requesting PEs (>=2).
- N_BITS, 32, operand/result width (matches pea_pkg N_BITS).
- LOG_N_REQ, $clog2(N_REQ), width of the grant index.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, synchronous, active-low.
- pea_ready_i  in  1  global advance enable; low freezes all state.
- req_valid_i  in  N_REQ  per-requester operand valid.
- req_a_i  in  N_REQ x N_BITS  dividend per requester.
- req_b_i  in  N_REQ x N_BITS  divisor per requester.
- req_rem_i  in  N_REQ  1 = REM (remainder is the primary result), 0 = DIVU.
- req_ready_o  out  N_REQ  one-hot acceptance; only the winner, only in IDLE.
- resp_valid_o  out  N_REQ  one-hot result valid to the owner.
- resp_ready_i  in  N_REQ  per-requester result acceptance.
- res_o  out  N_BITS  primary result (quotient for DIVU, remainder for REM).
- rem_q_o  out  N_BITS  secondary result (the other one of the pair).
- busy_o  out  1  high in BUSY or RESP.
- grant_idx_o  out  LOG_N_REQ  index of the current owner.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-low on rst_n_i.
- Reset (sampled at a clk_i edge with rst_n_i=0), including mid-operation:
  - state returns to IDLE; rr_ptr returns to 0.
  - All outputs are 0; any in-flight division is discarded and no response is issued.
- FSM states: IDLE, BUSY, RESP. No transition and no datapath update occurs while pea_ready_i=0; outputs hold.
- IDLE:
  - The winner is the first i with req_valid_i[i]=1, searching from rr_ptr upward with wrap.
  - req_ready_o[winner]=1 only when pea_ready_i=1. The handshake completes when valid&ready.
  - On handshake: latch a, b, rem and owner; cnt=0.
  - If b!=0, go to BUSY. If b==0, go to RESP with quotient='1 and remainder=a.
- BUSY:
  - Each enabled cycle performs one restoring step: shift {rem,quo} left, trial-subtract b, set the quotient bit.
  - Use an N_BITS+1-bit subtractor; no wrap errors for b > 2^(N_BITS-1).
  - cnt increments; after step N_BITS (cnt==N_BITS-1), go to RESP.
- RESP:
  - resp_valid_o[owner]=1; res_o/rem_q_o are driven from the final registers and held stable until accepted.
  - When resp_ready_i[owner]=1 and pea_ready_i=1, go to IDLE and set rr_ptr=(owner+1) mod N_REQ.
  - No new grant occurs in the same cycle; there is always one IDLE cycle between jobs.
- Latency (pea_ready_i steady high), handshake at edge G:
  - b!=0: resp_valid at G+N_BITS+1 (33 cycles for N_BITS=32).
  - b==0: resp_valid at G+1.
- Stall: deasserting pea_ready_i in BUSY extends latency by exactly the stalled cycle count; the result is unchanged.
- Requester inputs matter only in IDLE. Changes on the owner's req_* while BUSY have no effect.
- res_o, rem_q_o and grant_idx_o are 0 in IDLE.
- resp_valid_o and req_ready_o are never asserted in the same cycle.
- Arithmetic is unsigned only. a<b gives quotient 0, remainder a. a=0 gives 0,0.

Decomposition:
- pea_pkg holds:
  - div_arb_state_t enum {DA_IDLE, DA_BUSY, DA_RESP}.
  - N_DIV_REQ default constant.
- One natural sub-module, div_iter_core:
  - Inputs: start, enable, a, b. Outputs: done, quotient, remainder.
  - Holds the shift registers, counter and the divide-by-zero shortcut.
- The arbiter keeps the FSM, round-robin pointer and handshake logic.

Test Plan:
- Single request: req0 a=100, b=7, DIVU -> resp_valid_o=0001 at G+33, res_o=14, rem_q_o=2; with REM, res_o=2, rem_q_o=14.
- Divide by zero: req2 a=0x1234, b=0 -> resp_valid_o=0100 at G+1, res_o=0xFFFFFFFF (DIVU), rem_q_o=0x1234.
- Round-robin: all four requesters valid continuously -> grants in order 0,1,2,3,0; each subsequent grant occurs 1 cycle after the previous response is accepted.
- Stall: pea_ready_i=0 for 5 cycles mid-BUSY with a=0xFFFFFFFF, b=0x80000001 -> result at G+38, quotient 1, remainder 0x7FFFFFFE; outputs frozen during the stall.
- Response backpressure: resp_ready_i held 0 for 10 cycles -> resp_valid and res_o held stable; no req_ready_o to others; IDLE one cycle after acceptance.
- Reset mid-BUSY: rst_n_i=0 for one edge -> next cycle all outputs 0, state IDLE, rr_ptr=0; a pending req1 is then granted before req3.
